// File: rtl/map_transfer_dbuf.sv
// map_transfer_dbuf: double-buffered map-line store for the MTL renderer.
// The CPU fills a shadow bank over Avalon-MM and requests a commit; the shadow
// bank is copied to the active bank either on the next frame-sync rising edge
// (SWAP_MODE=0, tear-free) or in the cycle of the commit write (SWAP_MODE=1).
//
//   state   | meaning
//   IDLE    | no commit outstanding
//   PENDING | commit accepted, waiting for the next detected frame-sync edge
module map_transfer_dbuf #(
  parameter int NUM_LINES   = 8,
  parameter int LINE_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int SWAP_MODE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [ADDR_WIDTH-1:0]           avs_address,
  input  logic                            avs_write,
  input  logic [31:0]                     avs_writedata,
  input  logic                            avs_read,
  output logic [31:0]                     avs_readdata,
  input  logic                            frame_sync,
  output logic [NUM_LINES*LINE_WIDTH-1:0] map_lines,
  output logic                            irq,
  output logic                            swap_pulse
);

  localparam int BANK_W = NUM_LINES * LINE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR = ADDR_WIDTH'(NUM_LINES);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [BANK_W-1:0]      shadow;
  logic [BANK_W-1:0]      active;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_dly;
  logic                   edge_det;
  logic                   irq_en;
  logic [7:0]             swap_count;
  logic                   pending;
  logic                   ctrl_wr;
  logic                   commit_wr;
  logic                   do_swap;
  logic [31:0]            rd_mux;
  logic                   unused_wdata;

  assign ctrl_wr      = avs_write && (avs_address == CTRL_ADDR);
  assign commit_wr    = ctrl_wr && avs_writedata[0];
  assign pending      = (state == PENDING);
  assign map_lines    = active;
  assign unused_wdata = ^avs_writedata;

  // Synchronise frame_sync and register its rising edge (one detect per rise).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff  <= '0;
      sync_dly <= 1'b0;
      edge_det <= 1'b0;
    end else begin
      sync_ff  <= {sync_ff[SYNC_STAGES-2:0], frame_sync};
      sync_dly <= sync_ff[SYNC_STAGES-1];
      edge_det <= sync_ff[SYNC_STAGES-1] & ~sync_dly;
    end
  end

  // Swap state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and swap decision; immediate mode never leaves IDLE.
  always_comb begin
    state_nxt = state;
    do_swap   = 1'b0;
    if (SWAP_MODE != 0) begin
      do_swap   = commit_wr;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (commit_wr) state_nxt = PENDING;
        end
        PENDING: begin
          if (edge_det) begin
            do_swap   = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Shadow line writes; the active copy sees the shadow value from before any coincident write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '0;
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (avs_write && (avs_address == ADDR_WIDTH'(i))) begin
          shadow[i*LINE_WIDTH +: LINE_WIDTH] <= avs_writedata[LINE_WIDTH-1:0];
        end
      end
    end
  end

  // Bank copy, swap strobe and wrapping swap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active     <= '0;
      swap_pulse <= 1'b0;
      swap_count <= 8'd0;
    end else begin
      swap_pulse <= do_swap;
      if (do_swap) begin
        active     <= shadow;
        swap_count <= swap_count + 8'd1;
      end
    end
  end

  // Interrupt enable and level interrupt; a swap-triggered set beats an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= avs_writedata[1];
      if (do_swap && irq_en) begin
        irq <= 1'b1;
      end else if (ctrl_wr && avs_writedata[2]) begin
        irq <= 1'b0;
      end
    end
  end

  // Read mux over pre-write register values.
  always_comb begin
    rd_mux = 32'd0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (avs_address == ADDR_WIDTH'(i)) begin
        rd_mux = 32'(shadow[i*LINE_WIDTH +: LINE_WIDTH]);
      end
    end
    if (avs_address == CTRL_ADDR) begin
      rd_mux = {16'd0, swap_count, 5'd0, irq, irq_en, pending};
    end
  end

  // Registered read data, held while no read is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_map_transfer_dbuf.sv
// Testbench for map_transfer_dbuf: a frame-synced instance (defaults) and an
// immediate-swap instance (4 lines x 12 bits) checked against a bank-level model.
module tb_map_transfer_dbuf;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [6:0]   a0, a1;
  logic         w0, w1, r0, r1;
  logic [31:0]  wd0, wd1, rdata0, rdata1;
  logic         fs0, fs1;
  logic [255:0] map0;
  logic [47:0]  map1;
  logic         irq0, irq1, sp0, sp1;

  map_transfer_dbuf u_dut0 (
    .clk(clk), .reset_n(reset_n), .avs_address(a0), .avs_write(w0),
    .avs_writedata(wd0), .avs_read(r0), .avs_readdata(rdata0),
    .frame_sync(fs0), .map_lines(map0), .irq(irq0), .swap_pulse(sp0)
  );

  map_transfer_dbuf #(.NUM_LINES(4), .LINE_WIDTH(12), .ADDR_WIDTH(7), .SWAP_MODE(1), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .avs_address(a1), .avs_write(w1),
    .avs_writedata(wd1), .avs_read(r1), .avs_readdata(rdata1),
    .frame_sync(fs1), .map_lines(map1), .irq(irq1), .swap_pulse(sp1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int sp0_cnt = 0;
  int sp1_cnt = 0;

  always @(negedge clk) begin
    if (sp0 === 1'b1) sp0_cnt <= sp0_cnt + 1;
    if (sp1 === 1'b1) sp1_cnt <= sp1_cnt + 1;
  end

  // Reference model: banks as arrays, control state as plain flags.
  logic [31:0] sh0 [8];
  logic [31:0] ac0 [8];
  bit          pend0, irq_m0, ien0;
  logic [7:0]  cnt0;
  logic [11:0] sh1 [4];
  logic [11:0] ac1 [4];
  bit          irq_m1, ien1;
  logic [7:0]  cnt1;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin sh0[i] = '0; ac0[i] = '0; end
    for (int i = 0; i < 4; i++) begin sh1[i] = '0; ac1[i] = '0; end
    pend0 = 0; irq_m0 = 0; ien0 = 0; cnt0 = 8'd0;
    irq_m1 = 0; ien1 = 0; cnt1 = 8'd0;
  endfunction

  function automatic logic [255:0] pack0();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = ac0[i];
    return p;
  endfunction

  function automatic logic [47:0] pack1();
    logic [47:0] p;
    for (int i = 0; i < 4; i++) p[i*12 +: 12] = ac1[i];
    return p;
  endfunction

  function automatic logic [31:0] ctrl0();
    return {16'h0, cnt0, 5'h0, irq_m0, ien0, pend0};
  endfunction

  function automatic logic [31:0] ctrl1();
    return {16'h0, cnt1, 5'h0, irq_m1, ien1, 1'b0};
  endfunction

  function automatic void swap0();
    for (int i = 0; i < 8; i++) ac0[i] = sh0[i];
    cnt0 = cnt0 + 8'd1;
    if (ien0) irq_m0 = 1;
    pend0 = 0;
  endfunction

  function automatic void mwr0(input logic [6:0] a, input logic [31:0] d, input bit swapped, input bit ien_old);
    if (a < 7'd8) begin
      sh0[a[2:0]] = d;
    end else if (a == 7'd8) begin
      if (d[0] && !swapped) pend0 = 1;
      ien0 = d[1];
      if (d[2] && !(swapped && ien_old)) irq_m0 = 0;
    end
  endfunction

  function automatic void mwr1(input logic [6:0] a, input logic [31:0] d);
    bit ien_old;
    if (a < 7'd4) begin
      sh1[a[1:0]] = d[11:0];
    end else if (a == 7'd4) begin
      ien_old = ien1;
      if (d[0]) begin
        for (int i = 0; i < 4; i++) ac1[i] = sh1[i];
        cnt1 = cnt1 + 8'd1;
        if (ien_old) irq_m1 = 1;
      end
      ien1 = d[1];
      if (d[2] && !(d[0] && ien_old)) irq_m1 = 0;
    end
  endfunction

  task automatic wr0(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk); a0 = a; wd0 = d; w0 = 1'b1;
    @(negedge clk); w0 = 1'b0;
    mwr0(a, d, 1'b0, 1'b0);
  endtask

  task automatic rd0(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk); a0 = a; r0 = 1'b1;
    @(negedge clk); r0 = 1'b0;
    d = rdata0;
  endtask

  task automatic wr1(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk); a1 = a; wd1 = d; w1 = 1'b1;
    @(negedge clk); w1 = 1'b0;
    mwr1(a, d);
  endtask

  task automatic rd1(input logic [6:0] a, output logic [31:0] d);
    @(negedge clk); a1 = a; r1 = 1'b1;
    @(negedge clk); r1 = 1'b0;
    d = rdata1;
  endtask

  // One frame_sync rise on dut0; optionally a write lands in the detected-edge cycle.
  // Returns the negedge index (after the rise) where swap_pulse was first seen, 0 if none.
  task automatic frame0(input bit act, input logic [6:0] a, input logic [31:0] d, output int pulse_at);
    bit swapped;
    bit ien_old;
    swapped  = pend0;
    ien_old  = ien0;
    pulse_at = 0;
    @(negedge clk); fs0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 4) w0 = 1'b0;
      if (sp0 === 1'b1 && pulse_at == 0) pulse_at = i;
      if (i == 3 && act) begin a0 = a; wd0 = d; w0 = 1'b1; end
    end
    if (swapped) swap0();
    if (act) mwr0(a, d, swapped, ien_old);
    fs0 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    n_chk++; if (map0 !== '0) begin n_fail++; $display("FAIL reset_map0: got %h required 0", map0); end
    n_chk++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq0: got %b required 0", irq0); end
    n_chk++; if (sp0 !== 1'b0) begin n_fail++; $display("FAIL reset_pulse0: got %b required 0", sp0); end
    n_chk++; if (map1 !== '0) begin n_fail++; $display("FAIL reset_map1: got %h required 0", map1); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL reset_ctrl0: got %h required %h", d, ctrl0()); end
    rd1(7'd4, d);
    n_chk++; if (d !== ctrl1()) begin n_fail++; $display("FAIL reset_ctrl1: got %h required %h", d, ctrl1()); end
  endtask

  task automatic test_basic_swap();
    logic [31:0] d;
    int p;
    wr0(7'd0, 32'hDEADBEEF);
    wr0(7'd7, 32'h12345678);
    for (int i = 1; i < 7; i++) wr0(7'(i), $urandom);
    wr0(7'd8, 32'h3);
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL basic_ctrl_pending: got %h required %h", d, ctrl0()); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL basic_map_before: got %h required %h", map0, pack0()); end
    frame0(1'b0, 7'd0, 32'd0, p);
    n_chk++; if (p != 4) begin n_fail++; $display("FAIL basic_swap_latency: got %0d required 4", p); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL basic_map_after: got %h required %h", map0, pack0()); end
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL basic_irq_set: got %b required %b", irq0, irq_m0); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL basic_ctrl_count: got %h required %h", d, ctrl0()); end
    wr0(7'd8, 32'h6);
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL basic_irq_ack: got %b required %b", irq0, irq_m0); end
    for (int i = 0; i < 8; i++) begin
      rd0(7'(i), d);
      n_chk++; if (d !== sh0[i]) begin n_fail++; $display("FAIL basic_shadow_rd%0d: got %h required %h", i, d, sh0[i]); end
    end
  endtask

  task automatic test_edge_commit();
    logic [31:0] d, v;
    int p;
    wr0(7'd3, $urandom);
    frame0(1'b1, 7'd8, 32'h3, p);
    n_chk++; if (p != 0) begin n_fail++; $display("FAIL edge_commit_noswap: got pulse at %0d required none", p); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL edge_commit_map: got %h required %h", map0, pack0()); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL edge_commit_ctrl: got %h required %h", d, ctrl0()); end
    v = $urandom;
    frame0(1'b1, 7'd5, v, p);
    n_chk++; if (p != 4) begin n_fail++; $display("FAIL edge_next_swap: got %0d required 4", p); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL coincide_active_old: got %h required %h", map0, pack0()); end
    rd0(7'd5, d);
    n_chk++; if (d !== sh0[5]) begin n_fail++; $display("FAIL coincide_shadow_new: got %h required %h", d, sh0[5]); end
  endtask

  task automatic test_held_high();
    logic [31:0] d;
    int p, base;
    wr0(7'd1, $urandom);
    wr0(7'd8, 32'h3);
    base = sp0_cnt;
    @(negedge clk); fs0 = 1'b1;
    swap0();
    repeat (10) @(negedge clk);
    wr0(7'd2, $urandom);
    wr0(7'd8, 32'h3);
    repeat (86) @(negedge clk);
    n_chk++; if (sp0_cnt - base != 1) begin n_fail++; $display("FAIL held_one_swap: got %0d swaps required 1", sp0_cnt - base); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL held_map: got %h required %h", map0, pack0()); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL held_ctrl_pending: got %h required %h", d, ctrl0()); end
    fs0 = 1'b0;
    repeat (4) @(negedge clk);
    frame0(1'b0, 7'd0, 32'd0, p);
    n_chk++; if (p != 4) begin n_fail++; $display("FAIL held_second_swap: got %0d required 4", p); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL held_second_map: got %h required %h", map0, pack0()); end
  endtask

  task automatic test_ack_collision();
    int p;
    wr0(7'd8, 32'h6);
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL ack_pre_clear: got %b required %b", irq0, irq_m0); end
    wr0(7'd8, 32'h3);
    frame0(1'b1, 7'd8, 32'h6, p);
    n_chk++; if (p != 4) begin n_fail++; $display("FAIL ack_swap_happened: got %0d required 4", p); end
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL ack_set_wins: got %b required %b", irq0, irq_m0); end
    wr0(7'd8, 32'h0);
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL ien_clear_keeps_irq: got %b required %b", irq0, irq_m0); end
    wr0(7'd8, 32'h4);
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL ack_clears: got %b required %b", irq0, irq_m0); end
    wr0(7'd8, 32'h2);
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    int p, n, bad;
    n = 256 - int'(cnt0);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) begin
        rd0(7'd8, d);
        n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL wrap_count_255: got %h required %h", d, ctrl0()); end
      end
      wr0(7'($urandom_range(0, 7)), $urandom);
      wr0(7'd8, 32'h3);
      frame0(1'b0, 7'd0, 32'd0, p);
      if (p != 4) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL wrap_swap_timing: got %0d late swaps required 0", bad); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL wrap_count_0: got %h required %h", d, ctrl0()); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL wrap_map: got %h required %h", map0, pack0()); end
  endtask

  task automatic test_mode1();
    logic [31:0] d;
    int base;
    wr1(7'd4, 32'h2);
    wr1(7'd0, $urandom);
    wr1(7'd1, $urandom);
    wr1(7'd3, $urandom);
    wr1(7'd2, 32'hFFFF);
    n_chk++; if (map1 !== pack1()) begin n_fail++; $display("FAIL m1_map_before: got %h required %h", map1, pack1()); end
    wr1(7'd4, 32'h3);
    n_chk++; if (map1 !== pack1()) begin n_fail++; $display("FAIL m1_map_immediate: got %h required %h", map1, pack1()); end
    n_chk++; if (map1[35:24] !== sh1[2]) begin n_fail++; $display("FAIL m1_line2_trunc: got %h required %h", map1[35:24], sh1[2]); end
    n_chk++; if (sp1 !== 1'b1) begin n_fail++; $display("FAIL m1_pulse: got %b required 1", sp1); end
    n_chk++; if (irq1 !== irq_m1) begin n_fail++; $display("FAIL m1_irq: got %b required %b", irq1, irq_m1); end
    rd1(7'd4, d);
    n_chk++; if (d !== ctrl1()) begin n_fail++; $display("FAIL m1_ctrl_no_pending: got %h required %h", d, ctrl1()); end
    rd1(7'd6, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL m1_unmapped_rd: got %h required 0", d); end
    wr1(7'd5, $urandom);
    rd1(7'd5, d);
    n_chk++; if (d !== 32'd0) begin n_fail++; $display("FAIL m1_active_sel_rd: got %h required 0", d); end
    base = sp1_cnt;
    @(negedge clk); fs1 = 1'b1;
    repeat (8) @(negedge clk);
    fs1 = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (sp1_cnt != base) begin n_fail++; $display("FAIL m1_ignores_fsync: got %0d swaps required 0", sp1_cnt - base); end
    n_chk++; if (map1 !== pack1()) begin n_fail++; $display("FAIL m1_map_stable: got %h required %h", map1, pack1()); end
  endtask

  task automatic test_reset_pending();
    logic [31:0] d;
    int p;
    wr0(7'd4, $urandom);
    wr0(7'd8, 32'h3);
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL rstp_pending: got %h required %h", d, ctrl0()); end
    @(negedge clk); reset_n = 1'b0;
    #2;
    model_reset();
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL rstp_map0: got %h required %h", map0, pack0()); end
    n_chk++; if (irq0 !== irq_m0) begin n_fail++; $display("FAIL rstp_irq0: got %b required %b", irq0, irq_m0); end
    n_chk++; if (rdata0 !== 32'd0) begin n_fail++; $display("FAIL rstp_rdata0: got %h required 0", rdata0); end
    n_chk++; if (map1 !== pack1()) begin n_fail++; $display("FAIL rstp_map1: got %h required %h", map1, pack1()); end
    n_chk++; if (irq1 !== irq_m1) begin n_fail++; $display("FAIL rstp_irq1: got %b required %b", irq1, irq_m1); end
    @(negedge clk); reset_n = 1'b1;
    frame0(1'b0, 7'd0, 32'd0, p);
    n_chk++; if (p != 0) begin n_fail++; $display("FAIL rstp_no_swap: got pulse at %0d required none", p); end
    n_chk++; if (map0 !== pack0()) begin n_fail++; $display("FAIL rstp_map_after: got %h required %h", map0, pack0()); end
    rd0(7'd8, d);
    n_chk++; if (d !== ctrl0()) begin n_fail++; $display("FAIL rstp_ctrl: got %h required %h", d, ctrl0()); end
    rd0(7'd4, d);
    n_chk++; if (d !== sh0[4]) begin n_fail++; $display("FAIL rstp_shadow: got %h required %h", d, sh0[4]); end
  endtask

  initial begin
    a0 = '0; w0 = 1'b0; wd0 = '0; r0 = 1'b0; fs0 = 1'b0;
    a1 = '0; w1 = 1'b0; wd1 = '0; r1 = 1'b0; fs1 = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_basic_swap();
    test_edge_commit();
    test_held_high();
    test_ack_collision();
    test_wrap();
    test_mode1();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
